// File: rtl/serial_sub_nbit.sv
// Multi-cycle (n+1)-bit subtractor: k bits per clock, LSB slice first, borrow rippled
// between slices, with a start/busy/done handshake and registered diff/borrow outputs.
module serial_sub_nbit #(
   parameter int n = 15,
   parameter int k = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [n:0] a,
   input  logic [n:0] b,
   input  logic       bin,
   output logic [n:0] diff,
   output logic       borrow,
   output logic       busy,
   output logic       done
);

   localparam int L  = (n + 1) / k;
   localparam int CW = (L > 1) ? $clog2(L) : 1;
   localparam logic [CW-1:0] LAST = CW'(L - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [n:0]      r_a;
   logic [n:0]      r_b;
   logic            r_br;
   logic [n:0]      r_res;
   logic [n:0]      r_diff;
   logic            r_borrow;
   logic [CW-1:0]   r_cnt;

   logic            w_accept;
   logic            w_run;
   logic            w_last;
   logic [k:0]      w_slice;
   logic            w_bo;
   logic [n+k:0]    w_a_cat;
   logic [n+k:0]    w_b_cat;
   logic [n+k:0]    w_res_cat;
   logic [n:0]      w_a_shift;
   logic [n:0]      w_b_shift;
   logic [n:0]      w_res_next;

   assign w_run    = (r_state == S_RUN);
   assign w_accept = start && !w_run;
   assign w_last   = w_run && (r_cnt == LAST);

   // One k-bit slice per cycle; the extra MSB of the (k+1)-bit difference is the slice borrow.
   assign w_slice = {1'b0, r_a[k-1:0]} - {1'b0, r_b[k-1:0]} - {{k{1'b0}}, r_br};
   assign w_bo    = w_slice[k];

   // Concatenate-and-slice keeps the shifts legal even when k spans the full width.
   assign w_a_cat    = {{k{1'b0}}, r_a};
   assign w_b_cat    = {{k{1'b0}}, r_b};
   assign w_res_cat  = {w_slice[k-1:0], r_res};
   assign w_a_shift  = w_a_cat[n+k:k];
   assign w_b_shift  = w_b_cat[n+k:k];
   assign w_res_next = w_res_cat[n+k:k];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_next = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (w_last) w_state_next = S_DONE;
         end
         S_DONE: begin
            done         = 1'b1;
            w_state_next = start ? S_RUN : S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_br     <= 1'b0;
         r_res    <= '0;
         r_cnt    <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
      end else if (w_accept) begin
         r_a   <= a;
         r_b   <= b;
         r_br  <= bin;
         r_res <= '0;
         r_cnt <= '0;
      end else if (w_run) begin
         r_a   <= w_a_shift;
         r_b   <= w_b_shift;
         r_br  <= w_bo;
         r_res <= w_res_next;
         r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            r_diff   <= w_res_next;
            r_borrow <= w_bo;
         end
      end
   end

   assign diff   = r_diff;
   assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_sub_nbit.sv
// Bench for serial_sub_nbit: four instances (k=1,2,4,16) share operands; a per-instance
// scoreboard queue is filled when an op is issued and drained when that instance pulses done.
module tb_serial_sub_nbit;

   localparam int NDUT = 4;
   localparam int KS [NDUT] = '{1, 2, 4, 16};

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        bin;
      logic [16:0] exp;
   } sb_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        bin;
      logic [15:0] d;
      logic        br;
   } vec_t;

   logic              clk;
   logic              rst_n;
   logic [NDUT-1:0]   start_r;
   logic [15:0]       a_r;
   logic [15:0]       b_r;
   logic              bin_r;
   logic [15:0]       diff_w [NDUT];
   logic [NDUT-1:0]   borrow_w;
   logic [NDUT-1:0]   busy_w;
   logic [NDUT-1:0]   done_w;

   sb_t  exp_q [NDUT][$];
   int   checks;
   int   failures;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < NDUT; gi++) begin : g_dut
         serial_sub_nbit #(.n(15), .k(KS[gi])) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (start_r[gi]),
            .a      (a_r),
            .b      (b_r),
            .bin    (bin_r),
            .diff   (diff_w[gi]),
            .borrow (borrow_w[gi]),
            .busy   (busy_w[gi]),
            .done   (done_w[gi])
         );

         always @(negedge clk) begin
            if (done_w[gi]) begin
               sb_t         e;
               logic [16:0] got;
               logic [15:0] back;
               checks++;
               if (busy_w[gi]) begin
                  failures++;
                  $display("FAIL busy_with_done k=%0d got busy=1 required busy=0", KS[gi]);
               end
               if (exp_q[gi].size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_done k=%0d got done=1 with nothing outstanding", KS[gi]);
               end else begin
                  e    = exp_q[gi].pop_front();
                  got  = {borrow_w[gi], diff_w[gi]};
                  back = diff_w[gi] + e.b + 16'(e.bin);
                  checks += 2;
                  if (got !== e.exp) begin
                     failures++;
                     $display("FAIL result k=%0d a=%h b=%h bin=%0d got=%h required=%h",
                              KS[gi], e.a, e.b, e.bin, got, e.exp);
                  end
                  if (back !== e.a) begin
                     failures++;
                     $display("FAIL add_back k=%0d diff+b+bin got=%h required=%h",
                              KS[gi], back, e.a);
                  end
                  $display("op k=%0d a=%h b=%h bin=%0d -> diff=%h borrow=%0d",
                           KS[gi], e.a, e.b, e.bin, diff_w[gi], borrow_w[gi]);
               end
            end
         end
      end
   endgenerate

   function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic bin);
      return {1'b0, a} - {1'b0, b} - {16'd0, bin};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   // Issue one op to every instance at once and check each done arrives exactly L edges later.
   task automatic run_all(input logic [15:0] a, input logic [15:0] b, input logic bin,
                          input logic [16:0] exp);
      logic [NDUT-1:0] seen;
      seen = '0;
      @(negedge clk);
      a_r     = a;
      b_r     = b;
      bin_r   = bin;
      start_r = '1;
      for (int j = 0; j < NDUT; j++) exp_q[j].push_back('{a: a, b: b, bin: bin, exp: exp});
      @(posedge clk);
      #1;
      start_r = '0;
      for (int cyc = 1; cyc <= 20 && seen != '1; cyc++) begin
         @(posedge clk);
         #1;
         for (int j = 0; j < NDUT; j++) begin
            if (done_w[j] && !seen[j]) begin
               seen[j] = 1'b1;
               check($sformatf("latency_k%0d", KS[j]), 32'(cyc), 32'(16 / KS[j]));
            end
         end
      end
      for (int j = 0; j < NDUT; j++) begin
         if (!seen[j]) begin
            checks++;
            failures++;
            $display("FAIL timeout k=%0d got no done required done within 20 edges", KS[j]);
         end
      end
   endtask

   initial begin
      vec_t vecs [9];
      vecs[0] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      vecs[2] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0};
      vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0};
      vecs[4] = '{16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0};
      vecs[5] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
      vecs[6] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0};
      vecs[7] = '{16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0};
      vecs[8] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1};

      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      start_r  = '0;
      a_r      = '0;
      b_r      = '0;
      bin_r    = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      for (int j = 0; j < NDUT; j++) begin
         check($sformatf("reset_diff_k%0d", KS[j]), 32'(diff_w[j]), 32'h0);
         check($sformatf("reset_flags_k%0d", KS[j]),
               {29'd0, borrow_w[j], busy_w[j], done_w[j]}, 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++)
         run_all(vecs[i].a, vecs[i].b, vecs[i].bin, {vecs[i].br, vecs[i].d});

      // Hold start through RUN on k=4 and change operands mid-run; the first result must not
      // move, and the op accepted in the DONE cycle uses the new operands.
      @(negedge clk);
      a_r = 16'h8000; b_r = 16'h0001; bin_r = 1'b0;
      start_r[2] = 1'b1;
      exp_q[2].push_back('{a: 16'h8000, b: 16'h0001, bin: 1'b0, exp: 17'h07FFF});
      @(posedge clk);
      #1;
      check("b2b_busy_e0", {31'd0, busy_w[2]}, 32'h1);
      @(negedge clk);
      a_r = 16'hFFFF; b_r = 16'h0000; bin_r = 1'b1;
      exp_q[2].push_back('{a: 16'hFFFF, b: 16'h0000, bin: 1'b1, exp: 17'h0FFFE});
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk);
         #1;
         if (c < 4) check($sformatf("b2b_run%0d", c), {30'd0, busy_w[2], done_w[2]}, 32'h2);
         else       check("b2b_done1", {30'd0, busy_w[2], done_w[2]}, 32'h1);
      end
      @(posedge clk);
      #1;
      check("b2b_accept2", {31'd0, busy_w[2]}, 32'h1);
      start_r[2] = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk);
         #1;
         if (c == 4) check("b2b_done2", {30'd0, busy_w[2], done_w[2]}, 32'h1);
      end
      repeat (2) @(posedge clk);

      for (int i = 0; i < 250; i++) begin
         logic [15:0] ra;
         logic [15:0] rb;
         logic        rbin;
         ra   = 16'($urandom);
         rb   = (i % 16 == 0) ? ra : 16'($urandom);
         rbin = 1'($urandom);
         run_all(ra, rb, rbin, model(ra, rb, rbin));
      end

      // Abort a k=1 op partway through with reset: outputs clear, no done appears.
      run_all(16'h1234, 16'h0234, 1'b0, 17'h01000);
      @(posedge clk);
      @(negedge clk);
      a_r = 16'h5555; b_r = 16'h1111; bin_r = 1'b0;
      start_r[0] = 1'b1;
      @(posedge clk);
      #1;
      start_r[0] = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_diff_k1", 32'(diff_w[0]), 32'h0);
      check("abort_flags_k1", {29'd0, borrow_w[0], busy_w[0], done_w[0]}, 32'h0);
      check("abort_diff_k16", 32'(diff_w[3]), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("abort_idle_k1", {30'd0, busy_w[0], done_w[0]}, 32'h0);
      run_all(16'hABCD, 16'h0BCE, 1'b1, model(16'hABCD, 16'h0BCE, 1'b1));

      repeat (3) @(posedge clk);
      #1;
      for (int j = 0; j < NDUT; j++)
         check($sformatf("drained_k%0d", KS[j]), 32'(exp_q[j].size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
